// File: rtl/execute.sv
// Execute stage: single-cycle ALU/MUL, iterative restoring divider, and the E->M pipeline register.
// The divider stalls upstream while it runs and bubbles are pushed into M until the result is ready.
module execute #(
    parameter int WORD     = 32,
    parameter int REG_SIZE = 5,
    parameter int SHAMT_W  = 5,
    parameter int ALUOP_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                flushE,
    input  logic [WORD-1:0]     srcAE,
    input  logic [WORD-1:0]     srcBE,
    input  logic [WORD-1:0]     writeDataE,
    input  logic [WORD-1:0]     pcE,
    input  logic [REG_SIZE-1:0] writeRegE,
    input  logic [ALUOP_W-1:0]  aluControlE,
    input  logic                regWriteE,
    input  logic                memWriteE,
    input  logic                mem2regE,
    input  logic                branchE,
    input  logic                finishE,
    input  logic                validE,
    output logic                stallE,
    output logic [WORD-1:0]     ALUResultM,
    output logic [WORD-1:0]     writeDataM,
    output logic [WORD-1:0]     pcM,
    output logic [REG_SIZE-1:0] writeRegM,
    output logic                regWriteM,
    output logic                memWriteM,
    output logic                mem2regM,
    output logic                zeroM,
    output logic                branchM,
    output logic                finishM,
    output logic                validM
);

    localparam logic [ALUOP_W-1:0] OP_ADD  = ALUOP_W'(0),  OP_SUB  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(2),  OP_OR   = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(4),  OP_SLL  = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] OP_SRL  = ALUOP_W'(6),  OP_SRA  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(8),  OP_SLTU = ALUOP_W'(9);
    localparam logic [ALUOP_W-1:0] OP_MUL  = ALUOP_W'(10), OP_DIV  = ALUOP_W'(11);
    localparam logic [ALUOP_W-1:0] OP_DIVU = ALUOP_W'(12), OP_REM  = ALUOP_W'(13);
    localparam logic [ALUOP_W-1:0] OP_REMU = ALUOP_W'(14), OP_PASSB = ALUOP_W'(15);

    localparam logic [WORD-1:0]    MIN_WORD   = {1'b1, {(WORD-1){1'b0}}};
    localparam logic [SHAMT_W-1:0] LAST_COUNT = SHAMT_W'(WORD-1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [WORD-1:0]    rem_q, rem_d, quot_q, quot_d, divisor_q, divisor_d;
    logic               negQuot_q, negQuot_d, negRem_q, negRem_d;

    logic               isDiv, isSignedDiv, isRemOp, divByZero, divOverflow, special;
    logic [WORD-1:0]    magA, magB, divResult, specialResult, aluResult;
    logic [SHAMT_W-1:0] shamt;
    logic [WORD:0]      remShift, remDiff;

    assign isDiv       = (aluControlE == OP_DIV) || (aluControlE == OP_DIVU) ||
                         (aluControlE == OP_REM) || (aluControlE == OP_REMU);
    assign isSignedDiv = (aluControlE == OP_DIV) || (aluControlE == OP_REM);
    assign isRemOp     = (aluControlE == OP_REM) || (aluControlE == OP_REMU);
    assign divByZero   = (srcBE == '0);
    assign divOverflow = isSignedDiv && (srcAE == MIN_WORD) && (srcBE == '1);
    assign special     = divByZero || divOverflow;
    assign shamt       = srcBE[SHAMT_W-1:0];

    assign magA = (isSignedDiv && srcAE[WORD-1]) ? -srcAE : srcAE;
    assign magB = (isSignedDiv && srcBE[WORD-1]) ? -srcBE : srcBE;

    assign specialResult = divByZero ? (isRemOp ? srcAE : '1) : (isRemOp ? '0 : MIN_WORD);
    assign divResult     = isRemOp ? (negRem_q ? -rem_q : rem_q) : (negQuot_q ? -quot_q : quot_q);

    assign remShift = {rem_q, quot_q[WORD-1]};
    assign remDiff  = remShift - {1'b0, divisor_q};

    assign stallE = ((state_q == IDLE) && validE && isDiv && !special) || (state_q == RUN);

    // Result mux; the divider's answer is only meaningful in DONE, specials resolve immediately.
    always_comb begin
        aluResult = '0;
        case (aluControlE)
            OP_ADD:   aluResult = srcAE + srcBE;
            OP_SUB:   aluResult = srcAE - srcBE;
            OP_AND:   aluResult = srcAE & srcBE;
            OP_OR:    aluResult = srcAE | srcBE;
            OP_XOR:   aluResult = srcAE ^ srcBE;
            OP_SLL:   aluResult = srcAE << shamt;
            OP_SRL:   aluResult = srcAE >> shamt;
            OP_SRA:   aluResult = WORD'($signed(srcAE) >>> shamt);
            OP_SLT:   aluResult = {{(WORD-1){1'b0}}, $signed(srcAE) < $signed(srcBE)};
            OP_SLTU:  aluResult = {{(WORD-1){1'b0}}, srcAE < srcBE};
            OP_MUL:   aluResult = srcAE * srcBE;
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                if (state_q == DONE)
                    aluResult = divResult;
                else if (special)
                    aluResult = specialResult;
            end
            OP_PASSB: aluResult = srcBE;
            default:  aluResult = '0;
        endcase
    end

    // Divider next state; flush aborts unconditionally, everything else waits on en.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
        if (flushE) begin
            state_d = IDLE;
            count_d = '0;
        end else if (en) begin
            case (state_q)
                IDLE: if (validE && isDiv && !special) begin
                    state_d   = RUN;
                    count_d   = '0;
                    rem_d     = '0;
                    quot_d    = magA;
                    divisor_d = magB;
                    negQuot_d = isSignedDiv && (srcAE[WORD-1] ^ srcBE[WORD-1]);
                    negRem_d  = isSignedDiv && srcAE[WORD-1];
                end
                RUN: begin
                    count_d = count_q + 1'b1;
                    if (!remDiff[WORD]) begin
                        rem_d  = remDiff[WORD-1:0];
                        quot_d = {quot_q[WORD-2:0], 1'b1};
                    end else begin
                        rem_d  = remShift[WORD-1:0];
                        quot_d = {quot_q[WORD-2:0], 1'b0};
                    end
                    if (count_q == LAST_COUNT)
                        state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
        end
    end

    // E->M register: bubble whenever E is stalled, flushed or empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALUResultM <= '0;
            writeDataM <= '0;
            pcM        <= '0;
            writeRegM  <= '0;
            regWriteM  <= 1'b0;
            memWriteM  <= 1'b0;
            mem2regM   <= 1'b0;
            zeroM      <= 1'b0;
            branchM    <= 1'b0;
            finishM    <= 1'b0;
            validM     <= 1'b0;
        end else if (en) begin
            if (stallE || flushE || !validE) begin
                ALUResultM <= '0;
                writeDataM <= '0;
                pcM        <= '0;
                writeRegM  <= '0;
                regWriteM  <= 1'b0;
                memWriteM  <= 1'b0;
                mem2regM   <= 1'b0;
                zeroM      <= 1'b0;
                branchM    <= 1'b0;
                finishM    <= 1'b0;
                validM     <= 1'b0;
            end else begin
                ALUResultM <= aluResult;
                writeDataM <= writeDataE;
                pcM        <= pcE;
                writeRegM  <= writeRegE;
                regWriteM  <= regWriteE;
                memWriteM  <= memWriteE;
                mem2regM   <= mem2regE;
                zeroM      <= (aluResult == '0);
                branchM    <= branchE;
                finishM    <= finishE;
                validM     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage: directed cases from the stage's contract plus
// random operations checked against an arithmetic reference model and a divide stall-length rule.
module tb_execute;

    logic        clk, reset, en, flushE;
    logic [31:0] srcAE, srcBE, writeDataE, pcE;
    logic [4:0]  writeRegE;
    logic [3:0]  aluControlE;
    logic        regWriteE, memWriteE, mem2regE, branchE, finishE, validE;
    logic        stallE;
    logic [31:0] ALUResultM, writeDataM, pcM;
    logic [4:0]  writeRegM;
    logic        regWriteM, memWriteM, mem2regM, zeroM, branchM, finishM, validM;

    int checks = 0;
    int errors = 0;

    execute dut (
        .clk(clk), .reset(reset), .en(en), .flushE(flushE),
        .srcAE(srcAE), .srcBE(srcBE), .writeDataE(writeDataE), .pcE(pcE),
        .writeRegE(writeRegE), .aluControlE(aluControlE),
        .regWriteE(regWriteE), .memWriteE(memWriteE), .mem2regE(mem2regE),
        .branchE(branchE), .finishE(finishE), .validE(validE),
        .stallE(stallE), .ALUResultM(ALUResultM), .writeDataM(writeDataM), .pcM(pcM),
        .writeRegM(writeRegM), .regWriteM(regWriteM), .memWriteM(memWriteM),
        .mem2regM(mem2regM), .zeroM(zeroM), .branchM(branchM), .finishM(finishM),
        .validM(validM)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic isDivOp(input logic [3:0] op);
        return (op >= 4'd11) && (op <= 4'd14);
    endfunction

    // Reference results from plain integer arithmetic.
    function automatic logic [31:0] refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa = $signed(a);
        int sb = $signed(b);
        int s  = int'(b[4:0]);
        logic overflow = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << s;
            4'd6:  return a >> s;
            4'd7:  return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return a * b;
            4'd11: return (b == 0) ? 32'hFFFF_FFFF : overflow ? 32'h8000_0000 : 32'(sa / sb);
            4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd13: return (b == 0) ? a : overflow ? 32'h0 : 32'(sa % sb);
            4'd14: return (b == 0) ? a : a % b;
            default: return b;
        endcase
    endfunction

    function automatic int refStall(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signedOp = (op == 4'd11) || (op == 4'd13);
        if (!isDivOp(op) || b == 0) return 0;
        if (signedOp && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Issues one instruction, counts stall cycles, checks bubbles and the final M contents.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] ctrl);
        logic [31:0] expRes = refModel(op, a, b);
        logic [31:0] wd     = $urandom;
        logic [31:0] pc     = $urandom;
        logic [4:0]  rd     = 5'($urandom);
        int          stalls = 0;
        aluControlE = op; srcAE = a; srcBE = b;
        writeDataE = wd; pcE = pc; writeRegE = rd;
        {regWriteE, memWriteE, mem2regE, branchE, finishE} = ctrl;
        validE = 1'b1; en = 1'b1; flushE = 1'b0;
        #1;
        while (stallE === 1'b1 && stalls < 200) begin
            stalls++;
            @(posedge clk); #1;
            checkOutput("bubble validM", {31'b0, validM}, 32'd0);
        end
        checkOutput("stall cycles", 32'(stalls), 32'(refStall(op, a, b)));
        @(posedge clk); #1;
        checkOutput("ALUResultM", ALUResultM, expRes);
        checkOutput("zeroM", {31'b0, zeroM}, {31'b0, expRes == 0});
        checkOutput("validM", {31'b0, validM}, 32'd1);
        checkOutput("ctrlM", {27'b0, regWriteM, memWriteM, mem2regM, branchM, finishM}, {27'b0, ctrl});
        checkOutput("writeDataM", writeDataM, wd);
        checkOutput("pcM", pcM, pc);
        checkOutput("writeRegM", {27'b0, writeRegM}, {27'b0, rd});
    endtask

    initial begin
        int stalls;
        logic [3:0]  op;
        logic [31:0] a, b;

        reset = 1'b1; en = 1'b1; flushE = 1'b0; validE = 1'b0;
        srcAE = '0; srcBE = '0; writeDataE = '0; pcE = '0; writeRegE = '0; aluControlE = '0;
        {regWriteE, memWriteE, mem2regE, branchE, finishE} = '0;
        #22;
        checkOutput("reset ALUResultM", ALUResultM, 32'd0);
        checkOutput("reset validM", {31'b0, validM}, 32'd0);
        checkOutput("reset regWriteM", {31'b0, regWriteM}, 32'd0);
        checkOutput("reset stallE", {31'b0, stallE}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic ALU ops
        applyStimulus(4'd0, 32'd5, 32'd7, 5'b11111);
        // Disabled stage must hold M even with a new instruction in E
        aluControlE = 4'd1; srcAE = 32'd50; srcBE = 32'd8; validE = 1'b1; en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("en=0 hold ALUResultM", ALUResultM, 32'd12);
        checkOutput("en=0 hold validM", {31'b0, validM}, 32'd1);
        en = 1'b1; validE = 1'b0;
        #2; reset = 1'b1; #1;
        checkOutput("async reset ALUResultM", ALUResultM, 32'd0);
        checkOutput("async reset regWriteM", {31'b0, regWriteM}, 32'd0);
        #1; reset = 1'b0;
        @(posedge clk); #1;

        applyStimulus(4'd1, 32'h1234, 32'h1234, 5'b00010);
        applyStimulus(4'd7, 32'h8000_0000, 32'd4, 5'($urandom));
        // Empty slot produces a bubble
        validE = 1'b0; aluControlE = 4'd0; srcAE = 32'd3; srcBE = 32'd4;
        @(posedge clk); #1;
        checkOutput("invalid bubble validM", {31'b0, validM}, 32'd0);
        checkOutput("invalid bubble ALUResultM", ALUResultM, 32'd0);
        // Flushing a single-cycle op
        validE = 1'b1; flushE = 1'b1; regWriteE = 1'b1;
        @(posedge clk); #1;
        checkOutput("flush validM", {31'b0, validM}, 32'd0);
        checkOutput("flush regWriteM", {31'b0, regWriteM}, 32'd0);
        flushE = 1'b0;

        // Divides and special cases
        applyStimulus(4'd12, 32'd100, 32'd7, 5'($urandom));
        applyStimulus(4'd13, -32'sd7, 32'd2, 5'($urandom));
        applyStimulus(4'd11, 32'd12345, 32'd0, 5'($urandom));
        applyStimulus(4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 5'($urandom));
        applyStimulus(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 5'($urandom));
        applyStimulus(4'd14, 32'd9, 32'd0, 5'($urandom));
        applyStimulus(4'd11, -32'sd100, 32'd7, 5'($urandom));
        applyStimulus(4'd13, 32'd100, -32'sd7, 5'($urandom));

        // Flush in the middle of a divide
        aluControlE = 4'd11; srcAE = -32'sd100; srcBE = 32'd7; validE = 1'b1; en = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        flushE = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid-div flush validM", {31'b0, validM}, 32'd0);
        flushE = 1'b0; validE = 1'b0;
        #1;
        checkOutput("after flush stallE", {31'b0, stallE}, 32'd0);
        @(posedge clk); #1;
        applyStimulus(4'd0, 32'd40, 32'd2, 5'($urandom));

        // Freeze a running divide for 3 cycles
        aluControlE = 4'd12; srcAE = 32'd1000; srcBE = 32'd7; validE = 1'b1; en = 1'b1;
        #1;
        stalls = 0;
        while (stallE === 1'b1 && stalls < 200) begin
            stalls++;
            en = (stalls >= 6 && stalls <= 8) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
        end
        checkOutput("frozen divide stall cycles", 32'(stalls), 32'd36);
        @(posedge clk); #1;
        checkOutput("frozen divide result", ALUResultM, 32'd142);
        checkOutput("frozen divide validM", {31'b0, validM}, 32'd1);

        // Reset in the middle of a divide leaves no residual state
        aluControlE = 4'd11; srcAE = 32'd1000; srcBE = 32'd3; validE = 1'b1; en = 1'b1;
        repeat (6) @(posedge clk);
        #3; reset = 1'b1; validE = 1'b0; #1;
        checkOutput("mid-div reset stallE", {31'b0, stallE}, 32'd0);
        checkOutput("mid-div reset validM", {31'b0, validM}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        applyStimulus(4'd12, 32'd1000, 32'd7, 5'($urandom));

        // Random operations against the reference model
        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 1000));
            applyStimulus(op, a, b, 5'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
